rn_inject_arbiter: RTL
======================

Name: rn_inject_arbiter

Overview:
- Shares the single RN local injection port of a router between NUM_REQ protocol channels: req, evict, resp and data.
- Sits upstream of rn_router_sam. Its registered output feeds the SAM decode and then the router local input port.
- Runs round-robin arbitration with packet locking for multi-flit packets.
- Tracks downstream buffer credits so a flit is never sent without buffer space.

Parameters:
- FLIT_W, 256, width of the flit payload in bits.
- NUM_REQ, 4, number of requesting channels (index 0 req, 1 evict, 2 resp, 3 data).
- CREDIT_NUM, 4, depth of the downstream local-input buffer, in flits.
- REQ_IDX_W, $clog2(NUM_REQ), width of the requester index.
- CREDIT_W, $clog2(CREDIT_NUM+1), width of the credit counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-channel flit valid.
- req_last_i  in  NUM_REQ  per-channel last flit of packet (1 for single-flit packets).
- req_flit_i  in  NUM_REQ x FLIT_W  per-channel flit payload.
- req_ready_o  out  NUM_REQ  per-channel accept; one-hot or zero.
- tx_flit_v_o  out  1  registered flit valid toward rn_router_sam.
- tx_flit_o  out  FLIT_W  registered flit payload.
- tx_src_idx_o  out  REQ_IDX_W  channel index of the flit in tx_flit_o; selects the has_addr SAM path.
- tx_credit_return_i  in  1  one-cycle pulse; the downstream buffer freed one entry.
- credit_cnt_o  out  CREDIT_W  current credit count (observability).
- locked_o  out  1  arbiter is inside a multi-flit packet.

Behaviour:
- Reset values (rst=1 at a clk edge):
  - tx_flit_v_o=0, tx_flit_o=0, tx_src_idx_o=0.
  - credit counter = CREDIT_NUM, rr_ptr=0, state=IDLE, locked_o=0.
  - req_ready_o=0 while rst=1.
- Reset mid-packet discards the lock and any in-flight flit; credits restore to CREDIT_NUM.
- Grant condition: a transfer happens in a cycle when credit_cnt>0 and the selected channel has req_valid_i=1.
  - req_ready_o[g] is driven combinationally high in that same cycle. Valid/ready handshake: the flit is accepted when both are high.
  - No credit bypass: a tx_credit_return_i arriving in the same cycle does not enable a grant with credit_cnt=0.
- IDLE state:
  - g is the first valid index found scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - On a transfer with req_last_i[g]=0: state goes to LOCKED and lock_idx=g.
  - On a transfer with req_last_i[g]=1: state stays IDLE.
  - After any transfer in IDLE, rr_ptr = (g+1) mod NUM_REQ.
- LOCKED state:
  - Only lock_idx may be granted; other channels see ready=0 even with credit available.
  - A transfer with req_last_i=1 returns the state to IDLE. rr_ptr is already past lock_idx and is not changed.
  - A credit stall or req_valid_i=0 holds LOCKED indefinitely.
- locked_o = (state==LOCKED).
- Output register, latency 1:
  - The cycle after a transfer: tx_flit_v_o=1, tx_flit_o = accepted flit, tx_src_idx_o = g.
  - Otherwise tx_flit_v_o=0. tx_flit_o and tx_src_idx_o hold their last values.
  - There is no backpressure on tx; credits guarantee buffer space.
- Credit counter:
  - Decrements by 1 on a transfer.
  - Increments by 1 on tx_credit_return_i.
  - Both in the same cycle: unchanged.
  - Must never exceed CREDIT_NUM. A return while at CREDIT_NUM is an error: assertion fires and the counter saturates.
  - Must never underflow; guaranteed by the grant condition.
- Throughput: at most one flit per cycle. Sustained rate is 1 flit/cycle while credits remain.

Test Plan:
- Reset, then all 4 channels valid with single-flit packets (last=1) and credits=4. Required: grants 0,1,2,3 in consecutive cycles; tx_src_idx_o 0,1,2,3 one cycle later; credit_cnt_o ends at 0; no further ready.
- Channel 1 sends a 3-flit packet while channels 0 and 2 are valid; CREDIT_NUM=4, returns each cycle. Required: three consecutive grants to 1 with locked_o=1 for flits 1 and 2; the next grant goes to 2 (rr_ptr=2), not 0.
- Credits exhausted mid-packet on channel 3. Required: stays LOCKED with ready=0 for all channels. One tx_credit_return_i pulse leads to exactly one grant to channel 3 on the following cycle.
- Transfer and tx_credit_return_i in the same cycle with credit_cnt=2. Required: credit_cnt_o stays 2.
- With credit_cnt=0, a tx_credit_return_i arrives while channel 0 is valid. Required: no grant that cycle; grant the next cycle; credit_cnt_o goes 0→1→0.
- Assert rst while LOCKED on channel 2 with credit_cnt=1. Required on the next cycle: locked_o=0, credit_cnt_o=4, tx_flit_v_o=0. The first subsequent grant follows rr_ptr=0.

Source files
------------

// File: rtl/rn_inject_arbiter.sv
// rtl/rn_inject_arbiter.sv - RN local injection arbiter: round-robin with packet lock and credit flow control
module rn_inject_arbiter #(
  parameter int FLIT_W     = 256,
  parameter int NUM_REQ    = 4,
  parameter int CREDIT_NUM = 4,
  parameter int REQ_IDX_W  = $clog2(NUM_REQ),
  parameter int CREDIT_W   = $clog2(CREDIT_NUM + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  input  logic [NUM_REQ-1:0][FLIT_W-1:0] req_flit_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic                           tx_flit_v_o,
  output logic [FLIT_W-1:0]              tx_flit_o,
  output logic [REQ_IDX_W-1:0]           tx_src_idx_o,
  input  logic                           tx_credit_return_i,
  output logic [CREDIT_W-1:0]            credit_cnt_o,
  output logic                           locked_o
);

  localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_NUM);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [REQ_IDX_W-1:0]  rr_ptr;
  logic [REQ_IDX_W-1:0]  lock_idx;
  logic [REQ_IDX_W-1:0]  grant_idx;
  logic                  grant_valid;
  logic                  xfer;
  logic [CREDIT_W-1:0]   credit_cnt;

  function automatic logic [REQ_IDX_W-1:0] wrap_idx(input logic [REQ_IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[REQ_IDX_W-1:0];
  endfunction

  always_comb begin
    grant_idx   = rr_ptr;
    grant_valid = 1'b0;
    if (state == LOCKED) begin
      grant_idx   = lock_idx;
      grant_valid = req_valid_i[lock_idx];
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_valid && req_valid_i[wrap_idx(rr_ptr, i)]) begin
          grant_valid = 1'b1;
          grant_idx   = wrap_idx(rr_ptr, i);
        end
      end
    end
  end

  // Grant uses only the registered credit count; a same-cycle return never bypasses.
  assign xfer = !rst && grant_valid && (credit_cnt != '0);

  always_comb begin
    req_ready_o = '0;
    if (xfer) req_ready_o[grant_idx] = 1'b1;
  end

  assign credit_cnt_o = credit_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      lock_idx     <= '0;
      locked_o     <= 1'b0;
      credit_cnt   <= CREDIT_FULL;
      tx_flit_v_o  <= 1'b0;
      tx_flit_o    <= '0;
      tx_src_idx_o <= '0;
    end else begin
      tx_flit_v_o <= xfer;
      if (xfer) begin
        tx_flit_o    <= req_flit_i[grant_idx];
        tx_src_idx_o <= grant_idx;
      end

      case (state)
        IDLE: begin
          if (xfer) begin
            rr_ptr <= wrap_idx(grant_idx, 1);
            if (!req_last_i[grant_idx]) begin
              state    <= LOCKED;
              lock_idx <= grant_idx;
              locked_o <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (xfer && req_last_i[grant_idx]) begin
            state    <= IDLE;
            locked_o <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          locked_o <= 1'b0;
        end
      endcase

      if (xfer && !tx_credit_return_i)
        credit_cnt <= credit_cnt - 1'b1;
      else if (!xfer && tx_credit_return_i && credit_cnt != CREDIT_FULL)
        credit_cnt <= credit_cnt + 1'b1;
    end
  end

  credit_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(tx_credit_return_i && !xfer && credit_cnt == CREDIT_FULL));

endmodule
